seg_digit_driver: RTL and testbench

Downstream consumer of the one-hot digit-scan stage in the 4-digit seven-segment display path. Takes the scanner's one-hot select `st`, a 16-bit hex value and decimal points from the host logic, and drives registered segment and digit-enable pins. It double-buffers the value so updates land only at frame boundaries. It also inserts a blanking gap on every digit change to suppress ghosting, and optionally blanks leading zeros.

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_digit_driver.sv | 120 ++++++++++++
 tb/tb_seg_digit_driver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment display path:
// off pattern, first-digit select, hex-to-segment table and a one-hot test.
package seg_pkg;

   localparam logic [7:0] SEG_OFF   = 8'h00;
   localparam logic [3:0] ONEHOT_D0 = 4'b0001;

   // Segment order is {g,f,e,d,c,b,a}, active-high.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] code;
      case (nibble)
         4'h0: code = 7'h3F;
         4'h1: code = 7'h06;
         4'h2: code = 7'h5B;
         4'h3: code = 7'h4F;
         4'h4: code = 7'h66;
         4'h5: code = 7'h6D;
         4'h6: code = 7'h7D;
         4'h7: code = 7'h07;
         4'h8: code = 7'h7F;
         4'h9: code = 7'h6F;
         4'hA: code = 7'h77;
         4'hB: code = 7'h7C;
         4'hC: code = 7'h39;
         4'hD: code = 7'h5E;
         4'hE: code = 7'h79;
         default: code = 7'h71;
      endcase
      return code;
   endfunction

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to a-g segment decoder.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   assign segs = hex_to_seg(nibble);

endmodule

// File: rtl/seg_digit_driver.sv
// Four-digit seven-segment pin driver: frame-synchronous double buffering,
// anti-ghosting blank gap after each digit change, optional leading-zero blanking.
module seg_digit_driver
   import seg_pkg::*;
#(
   parameter int unsigned BLANK_CYC      = 2,
   parameter bit          LZ_BLANK       = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  st,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic [7:0]  seg,
   output logic [3:0]  dig,
   output logic        pending
);

   localparam logic [3:0] BLANK_INIT = 4'(BLANK_CYC);
   localparam logic [7:0] SEG_RST    = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic [3:0] DIG_RST    = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

   logic [3:0]  st_q;
   logic [3:0]  blank_cnt;
   logic [15:0] shadow_data, active_data;
   logic [3:0]  shadow_dp, active_dp;
   logic        pending_q;
   logic [7:0]  seg_q;
   logic [3:0]  dig_q;

   logic        sel_valid, change, frame;
   logic [1:0]  idx;
   logic [3:0]  nibble;
   logic [6:0]  hex_segs;
   logic        lz_hide;
   logic [7:0]  seg_n;
   logic [3:0]  dig_n;

   assign sel_valid = is_onehot4(st_q);
   assign change    = (st != st_q);
   // An invalid previous select never opens a frame, so garbage scans cannot swap buffers.
   assign frame     = sel_valid && (st_q != ONEHOT_D0) && (st == ONEHOT_D0);

   always_comb begin
      idx = 2'd0;
      if (st_q[1]) idx = 2'd1;
      if (st_q[2]) idx = 2'd2;
      if (st_q[3]) idx = 2'd3;
   end

   assign nibble = active_data[{idx, 2'b00} +: 4];

   seg_hex_decode u_hex (
      .nibble (nibble),
      .segs   (hex_segs)
   );

   always_comb begin
      lz_hide = 1'b0;
      case (idx)
         2'd3:    lz_hide = (active_data[15:12] == 4'd0);
         2'd2:    lz_hide = (active_data[15:8]  == 8'd0);
         2'd1:    lz_hide = (active_data[15:4]  == 12'd0);
         default: lz_hide = 1'b0;
      endcase
      lz_hide = lz_hide && LZ_BLANK;
   end

   always_comb begin
      seg_n = SEG_OFF;
      dig_n = 4'd0;
      if (sel_valid && (blank_cnt == 4'd0)) begin
         dig_n = st_q;
         seg_n = {active_dp[idx], lz_hide ? 7'd0 : hex_segs};
      end
   end

   // load is a single-cycle strobe with no back-pressure; the shadow always accepts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q        <= 4'd0;
         blank_cnt   <= 4'd0;
         shadow_data <= 16'd0;
         shadow_dp   <= 4'd0;
         active_data <= 16'd0;
         active_dp   <= 4'd0;
         pending_q   <= 1'b0;
         seg_q       <= SEG_RST;
         dig_q       <= DIG_RST;
      end else begin
         st_q <= st;
         if (change)
            blank_cnt <= BLANK_INIT;
         else if (blank_cnt != 4'd0)
            blank_cnt <= blank_cnt - 4'd1;

         if (frame && pending_q) begin
            active_data <= shadow_data;
            active_dp   <= shadow_dp;
         end
         if (load) begin
            shadow_data <= data_in;
            shadow_dp   <= dp_in;
            pending_q   <= 1'b1;
         end else if (frame && pending_q) begin
            pending_q   <= 1'b0;
         end

         seg_q <= SEG_ACTIVE_LOW ? ~seg_n : seg_n;
         dig_q <= SEG_ACTIVE_LOW ? ~dig_n : dig_n;
      end
   end

   assign seg     = seg_q;
   assign dig     = dig_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_seg_digit_driver.sv
// Bench for seg_digit_driver: four parameterisations share one stimulus stream;
// a driver queues hand-computed expectations and a monitor checks them per cycle.
module tb_seg_digit_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  st = 4'd0;
   logic [15:0] data_in = 16'd0;
   logic [3:0]  dp_in = 4'd0;
   logic        load = 1'b0;

   logic [7:0] seg_a, seg_b, seg_c, seg_d;
   logic [3:0] dig_a, dig_b, dig_c, dig_d;
   logic       pend_a, pend_b, pend_c, pend_d;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] cyc;
      logic [1:0]  inst;
      logic [7:0]  seg;
      logic [3:0]  dig;
      logic        pend;
   } exp_t;
   localparam int W = $bits(exp_t);
   logic [W-1:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seg_digit_driver #(.BLANK_CYC(0), .LZ_BLANK(1'b0), .SEG_ACTIVE_LOW(1'b0)) u_a (
      .clk(clk), .rst(rst), .st(st), .data_in(data_in), .dp_in(dp_in), .load(load),
      .seg(seg_a), .dig(dig_a), .pending(pend_a));
   seg_digit_driver #(.BLANK_CYC(3), .LZ_BLANK(1'b1), .SEG_ACTIVE_LOW(1'b0)) u_b (
      .clk(clk), .rst(rst), .st(st), .data_in(data_in), .dp_in(dp_in), .load(load),
      .seg(seg_b), .dig(dig_b), .pending(pend_b));
   seg_digit_driver #(.BLANK_CYC(0), .LZ_BLANK(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_c (
      .clk(clk), .rst(rst), .st(st), .data_in(data_in), .dp_in(dp_in), .load(load),
      .seg(seg_c), .dig(dig_c), .pending(pend_c));
   seg_digit_driver #(.BLANK_CYC(0), .LZ_BLANK(1'b1), .SEG_ACTIVE_LOW(1'b0)) u_d (
      .clk(clk), .rst(rst), .st(st), .data_in(data_in), .dp_in(dp_in), .load(load),
      .seg(seg_d), .dig(dig_d), .pending(pend_d));

   // driver tasks
   task automatic step(input logic r, input logic [3:0] s, input logic l,
                       input logic [15:0] d, input logic [3:0] p);
      @(negedge clk);
      rst = r; st = s; load = l; data_in = d; dp_in = p;
   endtask

   // expected outputs of one instance right after the coming edge
   task automatic expect_out(input logic [1:0] inst, input logic [7:0] s,
                             input logic [3:0] d, input logic p);
      exp_t e;
      e.cyc = 32'(cyc + 1);
      e.inst = inst; e.seg = s; e.dig = d; e.pend = p;
      exp_q.push_back(e);
   endtask

   // scoreboard monitor
   initial begin
      exp_t e;
      logic [7:0] gs;
      logic [3:0] gd;
      logic       gp;
      string      nm;
      forever begin
         @(posedge clk);
         #1;
         while (exp_q.size() != 0) begin
            e = exp_q[0];
            if (e.cyc != 32'(cyc)) break;
            exp_q.delete(0);
            case (e.inst)
               2'd0:    begin gs = seg_a; gd = dig_a; gp = pend_a; nm = "a_blank0_lz0"; end
               2'd1:    begin gs = seg_b; gd = dig_b; gp = pend_b; nm = "b_blank3_lz1"; end
               2'd2:    begin gs = seg_c; gd = dig_c; gp = pend_c; nm = "c_activelow"; end
               default: begin gs = seg_d; gd = dig_d; gp = pend_d; nm = "d_lz1"; end
            endcase
            checks++;
            if (gs !== e.seg || gd !== e.dig || gp !== e.pend) begin
               errors++;
               $display("FAIL %s cyc=%0d: seg=%h dig=%h pending=%b, expected seg=%h dig=%h pending=%b",
                        nm, cyc, gs, gd, gp, e.seg, e.dig, e.pend);
            end
         end
      end
   end

   initial begin
      // reset with st toggling
      step(1, 4'b0001, 0, 16'h0, 4'h0);
      expect_out(0, 8'h00, 4'h0, 0); expect_out(2, 8'hFF, 4'hF, 0);
      step(1, 4'b0010, 0, 16'h0, 4'h0);
      expect_out(0, 8'h00, 4'h0, 0); expect_out(2, 8'hFF, 4'hF, 0);

      // load 12AF, then frame boundary and scan
      step(0, 4'b1000, 0, 16'h0, 4'h0);
      step(0, 4'b1000, 1, 16'h12AF, 4'b0100);
      expect_out(0, 8'h3F, 4'h8, 1); expect_out(2, 8'hFF, 4'h7, 1);
      step(0, 4'b0001, 0, 16'h0, 4'h0);
      expect_out(0, 8'h3F, 4'h8, 0);
      step(0, 4'b0010, 0, 16'h0, 4'h0);
      expect_out(0, 8'h71, 4'h1, 0); expect_out(2, 8'h8E, 4'hE, 0);
      step(0, 4'b0100, 0, 16'h0, 4'h0);
      expect_out(0, 8'h77, 4'h2, 0); expect_out(1, 8'h00, 4'h0, 0);
      step(0, 4'b1000, 0, 16'h0, 4'h0);
      expect_out(0, 8'hDB, 4'h4, 0);
      step(0, 4'b1000, 0, 16'h0, 4'h0);
      expect_out(0, 8'h06, 4'h8, 0); expect_out(2, 8'hF9, 4'h7, 0);

      // blanking gap of 3 with each digit held 4 cycles
      step(0, 4'b0001, 0, 16'h0, 4'h0);
      step(0, 4'b0001, 0, 16'h0, 4'h0);
      expect_out(1, 8'h00, 4'h0, 0);
      step(0, 4'b0001, 0, 16'h0, 4'h0);
      step(0, 4'b0001, 0, 16'h0, 4'h0);
      expect_out(1, 8'h00, 4'h0, 0);
      step(0, 4'b0010, 0, 16'h0, 4'h0);
      expect_out(1, 8'h71, 4'h1, 0); expect_out(0, 8'h71, 4'h1, 0);
      step(0, 4'b0010, 0, 16'h0, 4'h0);
      expect_out(1, 8'h00, 4'h0, 0);
      step(0, 4'b0010, 0, 16'h0, 4'h0);
      step(0, 4'b0010, 0, 16'h0, 4'h0);
      expect_out(1, 8'h00, 4'h0, 0);
      step(0, 4'b0100, 1, 16'h0005, 4'b0100);
      expect_out(1, 8'h77, 4'h2, 1);

      // leading-zero blanking on 0005
      step(0, 4'b1000, 0, 16'h0, 4'h0);
      step(0, 4'b0001, 0, 16'h0, 4'h0);
      step(0, 4'b0010, 0, 16'h0, 4'h0);
      expect_out(3, 8'h6D, 4'h1, 0); expect_out(2, 8'h92, 4'hE, 0);
      step(0, 4'b0100, 0, 16'h0, 4'h0);
      expect_out(3, 8'h00, 4'h2, 0); expect_out(0, 8'h3F, 4'h2, 0);
      step(0, 4'b1000, 0, 16'h0, 4'h0);
      expect_out(3, 8'h80, 4'h4, 0); expect_out(2, 8'h7F, 4'hB, 0);
      step(0, 4'b1000, 1, 16'h7777, 4'h0);
      expect_out(3, 8'h00, 4'h8, 1);

      // back-to-back load, then load coinciding with the boundary
      step(0, 4'b1000, 1, 16'h1111, 4'h0);
      expect_out(0, 8'h3F, 4'h8, 1);
      step(0, 4'b0001, 1, 16'h2222, 4'h0);
      expect_out(0, 8'h3F, 4'h8, 1);
      step(0, 4'b0010, 0, 16'h0, 4'h0);
      expect_out(0, 8'h06, 4'h1, 1);
      step(0, 4'b0100, 0, 16'h0, 4'h0);
      expect_out(0, 8'h06, 4'h2, 1);
      step(0, 4'b1000, 0, 16'h0, 4'h0);
      expect_out(0, 8'h06, 4'h4, 1);
      step(0, 4'b0001, 0, 16'h0, 4'h0);
      expect_out(0, 8'h06, 4'h8, 0);
      step(0, 4'b0010, 0, 16'h0, 4'h0);
      expect_out(0, 8'h5B, 4'h1, 0);

      // invalid selects block the shadow transfer
      step(0, 4'b0011, 1, 16'h4444, 4'h0);
      expect_out(0, 8'h5B, 4'h2, 1);
      step(0, 4'b0000, 0, 16'h0, 4'h0);
      expect_out(0, 8'h00, 4'h0, 1);
      step(0, 4'b0001, 0, 16'h0, 4'h0);
      expect_out(0, 8'h00, 4'h0, 1);
      step(0, 4'b0001, 0, 16'h0, 4'h0);
      expect_out(0, 8'h5B, 4'h1, 1);

      // reset mid-frame with a load that must be ignored
      step(1, 4'b0010, 1, 16'h9999, 4'hF);
      expect_out(0, 8'h00, 4'h0, 0); expect_out(2, 8'hFF, 4'hF, 0);
      step(1, 4'b0100, 0, 16'h0, 4'h0);
      expect_out(0, 8'h00, 4'h0, 0);
      step(0, 4'b1000, 0, 16'h0, 4'h0);
      expect_out(0, 8'h00, 4'h0, 0);
      step(0, 4'b0001, 0, 16'h0, 4'h0);
      expect_out(0, 8'h3F, 4'h8, 0); expect_out(2, 8'hFF, 4'h7, 0);
      step(0, 4'b0010, 0, 16'h0, 4'h0);
      expect_out(0, 8'h3F, 4'h1, 0);

      // final report
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         errors += exp_q.size();
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
